lfsr_multi_stage: RTL and testbench

LFSR_MULTI_STAGE -- requirements
Module: lfsr_multi_stage

---
 rtl/lfsr_multi_stage.sv | 67 ++++++
 tb/tb_lfsr_multi_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lfsr_multi_stage.sv
// Multi-step Fibonacci LFSR (x^32+x^22+x^2+x+1): loads a seed on start and
// shifts N_STEPS times, then publishes the final state on lfsr_out.
module lfsr_multi_stage #(
    parameter int N_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seed,
    input  logic        start,
    output logic [31:0] lfsr_out,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [5:0] LAST_STEP = 6'(N_STEPS - 1);

    state_t      state;
    logic [5:0]  counter;
    logic [31:0] current_state;
    logic        feedback;
    logic [31:0] shifted;

    assign feedback = current_state[31] ^ current_state[21] ^ current_state[1] ^ current_state[0];
    assign shifted  = {current_state[30:0], feedback};

    // Seed is captured only on the accepting edge, so later seed changes never reach a run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            counter       <= 6'd0;
            current_state <= 32'h0000_0000;
            lfsr_out      <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        current_state <= seed;
                        counter       <= 6'd0;
                        busy          <= 1'b1;
                        state         <= RUN;
                    end
                end
                RUN: begin
                    current_state <= shifted;
                    if (counter == LAST_STEP) begin
                        lfsr_out <= shifted;
                        busy     <= 1'b0;
                        counter  <= 6'd0;
                        state    <= IDLE;
                    end else begin
                        counter <= counter + 6'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_multi_stage.sv
// Randomized self-checking bench for lfsr_multi_stage: a default-depth instance
// and an N_STEPS=1 instance are checked against a behavioural LFSR model.
module tb_lfsr_multi_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] seed, seed1;
    logic        start, start1;
    logic [31:0] lfsr_out, lfsr_out1;
    logic        busy, busy1;

    int n_tests = 0;
    int n_fail  = 0;

    lfsr_multi_stage dut (
        .clk(clk), .rst(rst), .seed(seed), .start(start),
        .lfsr_out(lfsr_out), .busy(busy)
    );

    lfsr_multi_stage #(.N_STEPS(1)) dut1 (
        .clk(clk), .rst(rst), .seed(seed1), .start(start1),
        .lfsr_out(lfsr_out1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Reference: shift n times, new LSB = parity of taps 31,21,1,0.
    function automatic logic [31:0] ref_lfsr(input logic [31:0] s, input int n);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < n; i++)
            v = (v << 1) | 32'(^(v & 32'h8020_0003));
        return v;
    endfunction

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; start1 = 1'b0; seed = '0; seed1 = '0;
        #3;
        n_tests++; if (lfsr_out !== 32'h0) begin n_fail++; $display("FAIL reset_lfsr_out got %h want 00000000", lfsr_out); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (dut.counter !== 6'd0) begin n_fail++; $display("FAIL reset_counter got %0d want 0", dut.counter); end
        n_tests++; if (dut.current_state !== 32'h0) begin n_fail++; $display("FAIL reset_state got %h want 00000000", dut.current_state); end
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (lfsr_out1 !== 32'h0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_dut1 got out=%h busy=%b want 00000000/0", lfsr_out1, busy1); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_step;
        logic [31:0] seeds [7];
        logic [31:0] want  [7];
        seeds[0] = 32'h0000_0001; want[0] = 32'h0000_0003;
        seeds[1] = 32'h8000_0000; want[1] = 32'h0000_0001;
        seeds[2] = 32'h0020_0000; want[2] = 32'h0040_0001;
        for (int i = 3; i < 7; i++) begin
            seeds[i] = $urandom;
            want[i]  = ref_lfsr(seeds[i], 1);
        end
        for (int i = 0; i < 7; i++) begin
            seed1 = seeds[i]; start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0; seed1 = $urandom;
            n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL step1_busy_high[%0d] got %b want 1", i, busy1); end
            @(posedge clk); #1;
            n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL step1_busy_low[%0d] got %b want 0", i, busy1); end
            n_tests++; if (lfsr_out1 !== want[i]) begin n_fail++; $display("FAIL step1_result[%0d] seed %h got %h want %h", i, seeds[i], lfsr_out1, want[i]); end
        end
    endtask

    task automatic test_runs;
        logic [31:0] seeds [6];
        logic [31:0] prev, want;
        int cycles;
        bit cnt_ok, hold_ok;
        seeds[0] = 32'h1234_FADC;
        seeds[1] = 32'h0000_0000;   // zero seed stays locked at zero
        for (int i = 2; i < 6; i++) seeds[i] = $urandom;
        for (int i = 0; i < 6; i++) begin
            prev = lfsr_out;
            want = ref_lfsr(seeds[i], 32);
            seed = seeds[i]; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; seed = $urandom;
            cycles = 0; cnt_ok = 1'b1; hold_ok = 1'b1;
            while (busy === 1'b1 && cycles < 100) begin
                if (dut.counter !== 6'(cycles)) cnt_ok = 1'b0;
                if (lfsr_out !== prev) hold_ok = 1'b0;
                cycles++;
                @(posedge clk); #1;
            end
            n_tests++; if (cycles != 32) begin n_fail++; $display("FAIL run_busy_len[%0d] got %0d want 32", i, cycles); end
            n_tests++; if (!cnt_ok) begin n_fail++; $display("FAIL run_counter_seq[%0d] got mismatch want 0..31", i); end
            n_tests++; if (!hold_ok) begin n_fail++; $display("FAIL run_out_hold[%0d] got change want %h", i, prev); end
            n_tests++; if (lfsr_out !== want) begin n_fail++; $display("FAIL run_result[%0d] seed %h got %h want %h", i, seeds[i], lfsr_out, want); end
            repeat (3) @(posedge clk);
            #1;
            n_tests++; if (lfsr_out !== want || busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold[%0d] got %h/%b want %h/0", i, lfsr_out, busy, want); end
        end
    endtask

    task automatic test_ignore_start;
        logic [31:0] a, want;
        int cycles;
        a = $urandom;
        want = ref_lfsr(a, 32);
        seed = a; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            if (cycles == 10) begin start = 1'b1; seed = ~a; end
            else start = 1'b0;
            cycles++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_tests++; if (cycles != 32) begin n_fail++; $display("FAIL ignore_busy_len got %0d want 32", cycles); end
        n_tests++; if (lfsr_out !== want) begin n_fail++; $display("FAIL ignore_result got %h want %h", lfsr_out, want); end
        @(posedge clk); #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_restart got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, b;
        int cycles;
        a = $urandom; b = $urandom;
        seed = a; start = 1'b1;
        @(posedge clk); #1;
        seed = b;
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin cycles++; @(posedge clk); #1; end
        n_tests++; if (cycles != 32 || lfsr_out !== ref_lfsr(a, 32)) begin n_fail++; $display("FAIL b2b_first got %0d/%h want 32/%h", cycles, lfsr_out, ref_lfsr(a, 32)); end
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_reaccept got busy=%b want 1", busy); end
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin cycles++; @(posedge clk); #1; end
        n_tests++; if (cycles != 32 || lfsr_out !== ref_lfsr(b, 32)) begin n_fail++; $display("FAIL b2b_second got %0d/%h want 32/%h", cycles, lfsr_out, ref_lfsr(b, 32)); end
    endtask

    task automatic test_reset_midrun;
        logic [31:0] c;
        int cycles;
        seed = $urandom; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", busy); end
        n_tests++; if (lfsr_out !== 32'h0) begin n_fail++; $display("FAIL midreset_out got %h want 00000000", lfsr_out); end
        n_tests++; if (dut.counter !== 6'd0 || dut.current_state !== 32'h0) begin n_fail++; $display("FAIL midreset_regs got %0d/%h want 0/00000000", dut.counter, dut.current_state); end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0 || lfsr_out !== 32'h0) begin n_fail++; $display("FAIL midreset_no_resume got %b/%h want 0/00000000", busy, lfsr_out); end
        c = $urandom;
        seed = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin cycles++; @(posedge clk); #1; end
        n_tests++; if (cycles != 32 || lfsr_out !== ref_lfsr(c, 32)) begin n_fail++; $display("FAIL postreset_run got %0d/%h want 32/%h", cycles, lfsr_out, ref_lfsr(c, 32)); end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_runs();
        test_ignore_start();
        test_back_to_back();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
